// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: counts rising edges of the asynchronous
// divided oscillator over a gate of gate_len system-clock cycles and latches
// the count (with a saturation flag) for readout.
module ring_freq_meter #(
  parameter int COUNT_WIDTH = 24,
  parameter int GATE_WIDTH  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   osc_in,
  input  logic                   start,
  input  logic                   cont,
  input  logic [GATE_WIDTH-1:0]  gate_len,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   s1_q, s2_q, s3_q;
  logic                   rise;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [GATE_WIDTH-1:0]  gate_cnt_q;
  logic [GATE_WIDTH-1:0]  gate_load;
  logic                   busy_q, done_q, overflow_q;
  logic [COUNT_WIDTH-1:0] result_q;

  // Three-flop chain: s1/s2 resolve metastability, s3 delays s2 for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= osc_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // A zero-length gate would never terminate the down-counter, so it runs as one cycle.
  assign gate_load = (gate_len == '0) ? GATE_WIDTH'(1) : gate_len;

  // Saturating next count: once all-ones, further edges only set the sticky flag.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (rise) begin
      if (&edge_cnt_q) begin
        sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  // Measurement sequencer; the final count (including the last window cycle's
  // edge) is latched on entry to DONE so result and done appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      gate_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= MEASURE;
            busy_q     <= 1'b1;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            gate_cnt_q <= gate_load;
          end
        end
        MEASURE: begin
          edge_cnt_q <= edge_cnt_d;
          sat_q      <= sat_d;
          gate_cnt_q <= gate_cnt_q - GATE_WIDTH'(1);
          if (gate_cnt_q == GATE_WIDTH'(1)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= edge_cnt_d;
            overflow_q <= sat_d;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (cont) begin
            state_q    <= MEASURE;
            busy_q     <= 1'b1;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            gate_cnt_q <= gate_load;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a wide instance and a 4-bit instance share all
// inputs; expected counts come from a log of oscillator rising edges and the
// window arithmetic (edges sampled in [start-1, start+n-2] are counted).
module tb_ring_freq_meter;
  localparam int GW = 24;
  localparam int CW = 24;
  localparam int CWS = 4;
  localparam int SAT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc_in = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic [GW-1:0] gate_len = '0;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [CW-1:0] res_a;
  logic [CWS-1:0] res_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ring_freq_meter #(.COUNT_WIDTH(CW), .GATE_WIDTH(GW)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_len(gate_len), .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a));

  ring_freq_meter #(.COUNT_WIDTH(CWS), .GATE_WIDTH(GW)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_len(gate_len), .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b));

  // Oscillator generator: changes only on falling clk edges.
  bit osc_run = 1'b0;
  bit osc_static = 1'b0;
  bit rand_len = 1'b0;
  int hi_len = 4;
  int lo_len = 4;
  int left = 1;
  always @(negedge clk) begin
    if (!osc_run) begin
      osc_in = osc_static;
    end else if (left <= 1) begin
      osc_in = ~osc_in;
      if (rand_len) left = int'($urandom_range(2, 7));
      else left = osc_in ? hi_len : lo_len;
    end else begin
      left = left - 1;
    end
  end

  // Edge log: cum[c] = number of oscillator rises first seen at clk edge <= c.
  int cyc = 0;
  int rises = 0;
  bit osc_prev = 1'b0;
  int cum [65536];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (osc_in === 1'b1 && !osc_prev) rises = rises + 1;
    osc_prev = (osc_in === 1'b1);
    cum[cyc] = rises;
  end

  function automatic int exp_edges(input int s, input int n);
    return cum[s + n - 2] - cum[s - 2];
  endfunction

  function automatic int sat_val(input int c);
    return (c > SAT_MAX) ? SAT_MAX : c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one start pulse and observes the window; no comparisons here.
  task automatic run_window(input int n, input int restart_at, output int s_edge,
                            output int busy_cyc, output int dones_a, output int dones_b,
                            output int r_a, output int r_b, output bit o_a, output bit o_b);
    int k;
    bit seen;
    busy_cyc = 0; dones_a = 0; dones_b = 0; r_a = -1; r_b = -1; o_a = 0; o_b = 0; seen = 0;
    @(negedge clk);
    gate_len = GW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    s_edge = cyc;
    @(negedge clk);
    start = 1'b0;
    gate_len = GW'($urandom_range(0, 50));
    k = 1;
    while (!seen && k <= n + 20) begin
      if (busy_a) busy_cyc++;
      if (done_b) dones_b++;
      if (done_a) begin
        dones_a++;
        seen = 1;
        r_a = int'(res_a); r_b = int'(res_b); o_a = ovf_a; o_b = ovf_b;
      end else begin
        start = (k == restart_at);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy_a) busy_cyc++;
      if (done_a) dones_a++;
      if (done_b) dones_b++;
    end
    $display("[TB] window n=%0d start_edge=%0d busy=%0d dones=%0d result=%0d/%0d overflow=%0d/%0d",
             n, s_edge, busy_cyc, dones_a, r_a, r_b, o_a, o_b);
  endtask

  task automatic test_reset();
    hi_len = 4; lo_len = 4; osc_run = 1;
    repeat (3) @(negedge clk);
    tests_run++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b/%b want 0", busy_a, busy_b); end
    tests_run++; if (done_a !== 1'b0 || done_b !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b/%b want 0", done_a, done_b); end
    tests_run++; if (res_a !== '0 || res_b !== '0) begin tests_failed++; $display("FAIL reset_result got %0d/%0d want 0", res_a, res_b); end
    tests_run++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b/%b want 0", ovf_a, ovf_b); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_phase_aligned();
    int s, bc, da, db, ra, rb, e; bit oa, ob;
    hi_len = 4; lo_len = 4;
    run_window(1000, 0, s, bc, da, db, ra, rb, oa, ob);
    e = exp_edges(s, 1000);
    tests_run++; if (bc !== 1000) begin tests_failed++; $display("FAIL phase_busy got %0d want 1000", bc); end
    tests_run++; if (da !== 1 || db !== 1) begin tests_failed++; $display("FAIL phase_done_count got %0d/%0d want 1", da, db); end
    tests_run++; if (ra !== e || e !== 125) begin tests_failed++; $display("FAIL phase_result got %0d want %0d (model), 125", ra, e); end
    tests_run++; if (oa !== 1'b0) begin tests_failed++; $display("FAIL phase_overflow got %b want 0", oa); end
  endtask

  task automatic test_saturation();
    int s, bc, da, db, ra, rb, e; bit oa, ob;
    hi_len = 2; lo_len = 2;
    repeat (10) @(negedge clk);
    run_window(200, 0, s, bc, da, db, ra, rb, oa, ob);
    e = exp_edges(s, 200);
    tests_run++; if (rb !== sat_val(e) || rb !== 15) begin tests_failed++; $display("FAIL sat_result got %0d want %0d", rb, sat_val(e)); end
    tests_run++; if (ob !== 1'b1) begin tests_failed++; $display("FAIL sat_overflow got %b want 1", ob); end
    tests_run++; if (ra !== e) begin tests_failed++; $display("FAIL sat_wide_result got %0d want %0d", ra, e); end
    run_window(40, 0, s, bc, da, db, ra, rb, oa, ob);
    e = exp_edges(s, 40);
    tests_run++; if (rb !== sat_val(e) || rb !== 10) begin tests_failed++; $display("FAIL sat_short_result got %0d want %0d", rb, sat_val(e)); end
    tests_run++; if (ob !== 1'b0) begin tests_failed++; $display("FAIL sat_short_overflow got %b want 0", ob); end
  endtask

  task automatic test_ignored_start();
    int s, bc, da, db, ra, rb, e; bit oa, ob;
    hi_len = 4; lo_len = 4;
    run_window(1000, 300, s, bc, da, db, ra, rb, oa, ob);
    e = exp_edges(s, 1000);
    tests_run++; if (bc !== 1000) begin tests_failed++; $display("FAIL ignored_start_busy got %0d want 1000", bc); end
    tests_run++; if (da !== 1) begin tests_failed++; $display("FAIL ignored_start_done_count got %0d want 1", da); end
    tests_run++; if (ra !== e) begin tests_failed++; $display("FAIL ignored_start_result got %0d want %0d", ra, e); end
  endtask

  task automatic test_reset_mid_window();
    int s, bc, da, db, ra, rb, e, stray; bit oa, ob;
    hi_len = 2; lo_len = 2;
    stray = 0;
    @(negedge clk);
    gate_len = GW'(1000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", busy_a); end
    tests_run++; if (res_a !== '0 || res_b !== '0) begin tests_failed++; $display("FAIL midrst_result got %0d/%0d want 0", res_a, res_b); end
    tests_run++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin tests_failed++; $display("FAIL midrst_overflow got %b/%b want 0", ovf_a, ovf_b); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done_a || busy_a) stray++;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL midrst_after_release got %0d busy/done cycles want 0", stray); end
    run_window(8, 0, s, bc, da, db, ra, rb, oa, ob);
    e = exp_edges(s, 8);
    tests_run++; if (ra !== e || e !== 2) begin tests_failed++; $display("FAIL midrst_new_result got %0d want %0d (model), 2", ra, e); end
    tests_run++; if (da !== 1) begin tests_failed++; $display("FAIL midrst_new_done_count got %0d want 1", da); end
  endtask

  task automatic test_min_window();
    int s, bc, da, db, ra, rb, e; bit oa, ob;
    osc_static = 1; osc_run = 0;
    repeat (6) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      run_window(n, 0, s, bc, da, db, ra, rb, oa, ob);
      e = exp_edges(s, 1);
      tests_run++; if (bc !== 1) begin tests_failed++; $display("FAIL min_busy n=%0d got %0d want 1", n, bc); end
      tests_run++; if (da !== 1) begin tests_failed++; $display("FAIL min_done_count n=%0d got %0d want 1", n, da); end
      tests_run++; if (ra !== e || e !== 0) begin tests_failed++; $display("FAIL min_result n=%0d got %0d want %0d", n, ra, e); end
    end
    osc_run = 1;
  endtask

  task automatic test_continuous();
    int s, k, e, stray;
    bit seen;
    hi_len = 4; lo_len = 4; rand_len = 0;
    repeat (10) @(negedge clk);
    cont = 1'b1;
    gate_len = GW'(800);
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      seen = 0; k = 0;
      while (!seen && k < 900) begin
        if (done_a) seen = 1;
        else begin @(negedge clk); k++; end
      end
      e = exp_edges(s + w * 801, 800);
      $display("[TB] continuous window %0d done_cycle=%0d result=%0d", w, cyc, res_a);
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL cont_done_seen w=%0d got none want pulse", w); end
      tests_run++; if (cyc !== s + (w + 1) * 801 - 1) begin tests_failed++; $display("FAIL cont_period w=%0d got cycle %0d want %0d", w, cyc, s + (w + 1) * 801 - 1); end
      tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL cont_busy_in_done w=%0d got %b want 0", w, busy_a); end
      tests_run++; if (int'(res_a) !== e || e !== 100) begin tests_failed++; $display("FAIL cont_result w=%0d got %0d want %0d (model), 100", w, res_a, e); end
      @(negedge clk);
      if (w == 1) begin
        repeat (100) @(negedge clk);
        cont = 1'b0;
      end
    end
    stray = 0;
    repeat (20) begin
      if (busy_a || done_a) stray++;
      @(negedge clk);
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL cont_return_idle got %0d busy/done cycles want 0", stray); end
  endtask

  task automatic test_random();
    int s, bc, da, db, ra, rb, e, n; bit oa, ob;
    rand_len = 1;
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, 300));
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_window(n, 0, s, bc, da, db, ra, rb, oa, ob);
      e = exp_edges(s, n);
      tests_run++; if (bc !== n) begin tests_failed++; $display("FAIL rand_busy i=%0d got %0d want %0d", i, bc, n); end
      tests_run++; if (da !== 1 || db !== 1) begin tests_failed++; $display("FAIL rand_done_count i=%0d got %0d/%0d want 1", i, da, db); end
      tests_run++; if (ra !== e || oa !== 1'b0) begin tests_failed++; $display("FAIL rand_wide i=%0d got %0d ovf %b want %0d ovf 0", i, ra, oa, e); end
      tests_run++; if (rb !== sat_val(e) || ob !== (e > SAT_MAX)) begin tests_failed++; $display("FAIL rand_narrow i=%0d got %0d ovf %b want %0d ovf %b", i, rb, ob, sat_val(e), e > SAT_MAX); end
    end
    rand_len = 0;
  endtask

  initial begin
    test_reset();
    test_phase_aligned();
    test_saturation();
    test_ignored_start();
    test_reset_mid_window();
    test_min_window();
    test_continuous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
- Measures the frequency of the divided ring-oscillator output by counting its rising edges over a fixed window of system-clock cycles.
- The oscillator net is asynchronous to clk. Inside the block it is synchronised, edge-detected and counted.
- The result is latched for readout by the host or debug logic.
- The divider ratio must be chosen so that osc_in stays below clk/2.

Parameters:
- COUNT_WIDTH, 24, width of the edge counter and of the result.
- GATE_WIDTH, 24, width of gate_len and of the internal gate down-counter.

Ports:
- clk  input  1  system clock; sole clock domain.
- rst  input  1  asynchronous, active-high reset.
- osc_in  input  1  divided oscillator signal; asynchronous to clk.
- start  input  1  one-cycle request to begin a measurement.
- cont  input  1  continuous mode: re-arm automatically after each window.
- gate_len  input  GATE_WIDTH  window length in clk cycles; sampled when a measurement starts.
- busy  output  1  high while a window is open.
- done  output  1  one-cycle pulse when result updates.
- result  output  COUNT_WIDTH  rising edges counted in the last completed window.
- overflow  output  1  last completed window saturated the counter.

Behaviour:
- Reset, asynchronous: every flop clears. This gives busy=0, done=0, result=0, overflow=0, synchroniser=000, FSM=IDLE.
- Reset asserted mid-window aborts the window. No done pulse is issued and the partial count is discarded.

Synchroniser:
- osc_in feeds s1 -> s2 -> s3 on clk.
- rise = s2 & ~s3.
- Latency: an osc_in rising edge produces rise 2 clk edges later and is counted on the 3rd.
- Synchroniser flops run in every state, so no flush is needed on start.

FSM states: IDLE, MEASURE, DONE.
- IDLE: busy=0.
  - If start=1, go to MEASURE on the next edge.
  - On that same edge: edge_cnt=0, sat=0, gate_cnt=gate_len. gate_len=0 is treated as 1.
- MEASURE: busy=1.
  - Each cycle, if rise=1 then edge_cnt++.
  - If edge_cnt is already all-ones, it holds and sat=1 instead.
  - Each cycle gate_cnt--.
  - The cycle with gate_cnt==1 is the last window cycle. Its rise is included in the count, and the FSM goes to DONE next.
  - The window is exactly gate_len clk cycles: the gate_len cycles in which busy is high.
- DONE: one cycle. done=1, result<=final count, overflow<=sat.
  - result and overflow hold until the next DONE.
  - If cont=1: reload gate_cnt from gate_len, clear edge_cnt and sat, go to MEASURE, with busy staying low for this single cycle. A rise in this DONE cycle is not counted.
  - Else go to IDLE.

Boundary rules:
- start while busy or in DONE is ignored; it is not queued.
- Deasserting cont during MEASURE takes effect at the next DONE.
- gate_len changes during a window have no effect until the next load.
- Saturation: edge_cnt never wraps.

Resolution and accuracy:
- Frequency = result * f_clk / gate_len.
- ±1 count uncertainty from phase alignment.
- Correct only while osc_in high and low times each exceed one clk period.

Test Plan:
1. Phase-aligned count: clk period 10ns, osc_in square wave period 80ns, gate_len=1000, start pulse.
   -> busy high exactly 1000 cycles, single done pulse, result=125, overflow=0.
2. Saturation: COUNT_WIDTH=4, osc period 40ns, gate_len=200.
   -> result=15, overflow=1. A following run with gate_len=40 gives result=10, overflow=0.
3. Ignored start: pulse start again 300 cycles into a gate_len=1000 window.
   -> no restart, busy still falls after cycle 1000, exactly one done pulse.
4. Reset mid-window: assert rst at cycle 500 of a window, release, then start with gate_len=8 and osc period 40ns.
   -> during rst: busy=0, result=0, overflow=0. After the new window: result=2, done once.
5. Minimum window: gate_len=0 and gate_len=1, osc static high.
   -> both give busy high for 1 cycle, done, result=0.
6. Continuous mode: cont=1, osc period 80ns, gate_len=800.
   -> done pulses every 801 cycles, each result=100. Clear cont and the FSM returns to IDLE after the current done.
